sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Successive-approximation search engine: the initiator side of the unsigned less-than comparator interface.
- Drives the probe operand into an external sltu instance, whose other operand is a hidden target T.
- Consumes the comparator's lt output and reconstructs T exactly, one bit per step, MSB first.
- Used for threshold discovery and for closed-loop self-check of the sltu datapath.

Parameters:
- N, 32, operand width in bits (N >= 2).
- WAIT, 0, extra cycles per step to cover comparator pipeline latency (0 = combinational comparator).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a new search; accepted only in IDLE.
- ready  out  1  high in IDLE; start accepted when start & ready.
- busy  out  1  high in PROBE.
- probe  out  N  registered operand driven to comparator input b; comparator input a is T.
- lt  in  1  comparator result, defined as (T < probe), unsigned.
- done  out  1  one-cycle pulse; result valid in that cycle.
- result  out  N  recovered T; held from done until the next accepted start.

Behaviour:
- Reset (rst_n=0 at an edge), regardless of state:
  - state=IDLE.
  - probe=0, result=0, acc=0, done=0, busy=0, ready=1.
  - Any search in progress is abandoned; no done pulse.
- States: IDLE, PROBE, DONE.
- IDLE:
  - ready=1.
  - start=1 at edge E: state=PROBE, k=N-1, acc=0, cnt=0, probe=1<<(N-1).
  - result is not cleared on start; it keeps the previous value until the new DONE.
- PROBE:
  - busy=1, ready=0.
  - Each step holds probe stable for 1+WAIT cycles.
  - While cnt<WAIT: cnt increments; lt is ignored.
  - When cnt==WAIT: sample lt; acc[k] = ~lt (bit kept iff trial <= T).
  - If k>0: k=k-1, cnt=0, probe = acc_new | (1<<(k-1)).
  - If k==0: result=acc_new, state=DONE, probe unchanged.
- DONE:
  - done=1 for exactly one cycle; ready=0, busy=0.
  - Next edge: state=IDLE, done=0.
- Latency:
  - lt samples occur at edges E+(1+WAIT)*j for j=1..N.
  - done is high in the cycle following edge E+N*(1+WAIT).
  - N=32, WAIT=0: done in cycle 33 after acceptance.
- start while busy or in DONE: ignored, not queued.
- Back-to-back: start asserted in the cycle after done is accepted at the IDLE edge; minimum spacing between starts is N*(1+WAIT)+2 edges.
- Arithmetic:
  - Pure bit-set operations; no adder.
  - k counter width is clog2(N); cnt width is clog2(WAIT+1), minimum 1.
- Boundaries:
  - T=0: every step sees lt=1; result=0.
  - T=2^N-1: every step sees lt=0; result all ones.
  - lt changing during WAIT cycles has no effect.
  - X on lt outside sample edges must not propagate.

Test Plan:
- N=32, WAIT=0, T=0x00000000: start pulsed -> 32 probes 0x80000000, 0x40000000, ..., 0x00000001; done in cycle 33; result=0x00000000.
- N=32, WAIT=0, T=0xFFFFFFFF and T=0x80000000: result equals T; first probe=0x80000000; second probe 0xC0000000 in both cases.
- N=32, WAIT=2, T=0x12345678: each probe is held 3 cycles; done in cycle 97; result=0x12345678; lt glitches forced during wait cycles leave result unchanged.
- N=2, WAIT=0, T exhaustive over 0..3 via a real sltu #(.N(2)) instance: result==T every time; 3-edge cadence from start to done.
- N=32: 512 $random targets back-to-back through a real sltu instance -> result==T each run. During the same sequence, a start pulse injected mid-search is ignored: the probe sequence is unaltered and ready stays 0.
- Reset mid-search: rst_n=0 at step 10 of T=0xDEADBEEF -> next cycle probe=0, result=0, ready=1, no done pulse. A fresh start then yields result=0xDEADBEEF.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search: recovers a hidden target T one bit per step, MSB first, from an external (T < probe) comparator.
// Latency: N*(1+WAIT) edges from accepted start to the edge that raises done; done is a single-cycle pulse.
// Backpressure: start is taken only while ready (IDLE); a start during a search or in DONE is dropped, not queued.
module sar_search #(
    parameter int N    = 32,
    parameter int WAIT = 0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic [N-1:0] probe_o,
    input  logic         lt_i,
    output logic         done_o,
    output logic [N-1:0] result_o
);

    localparam int KW = $clog2(N);
    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    localparam logic [KW-1:0] K_TOP    = KW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT);
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q,  state_d;
    logic [KW-1:0] k_q,      k_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [N-1:0]  acc_q,    acc_d;
    logic [N-1:0]  probe_q,  probe_d;
    logic [N-1:0]  result_q, result_d;

    logic          step_end;
    logic          last_step;
    logic [N-1:0]  bit_k;
    logic [N-1:0]  acc_new;

    // The trial bit k is kept iff the comparator says T is not below the probe.
    // acc_new is only consumed on the sample edge, so lt_i at any other time is a don't-care.
    assign step_end  = (cnt_q == CNT_LAST);
    assign last_step = (k_q == '0);
    assign bit_k     = ONE << k_q;
    assign acc_new   = lt_i ? acc_q : (acc_q | bit_k);

    // State and datapath registers, synchronous active-low reset abandons any search.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            probe_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            probe_q  <= probe_d;
            result_q <= result_d;
        end
    end

    // Next-state: one pass through PROBE per search, DONE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_PROBE;
            S_PROBE: if (step_end && last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-values: hold probe for 1+WAIT cycles, then fold in lt and set the next trial bit.
    always_comb begin
        k_d      = k_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        probe_d  = probe_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_d     = K_TOP;
                    cnt_d   = '0;
                    acc_d   = '0;
                    probe_d = ONE << K_TOP;
                end
            end
            S_PROBE: begin
                if (!step_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    acc_d = acc_new;
                    if (!last_step) begin
                        k_d     = k_q - 1'b1;
                        cnt_d   = '0;
                        probe_d = acc_new | (bit_k >> 1);
                    end else begin
                        result_d = acc_new;
                    end
                end
            end
            default: ;
        endcase
    end

    // Status outputs decode directly from the current state.
    always_comb begin
        ready_o = (state_q == S_IDLE);
        busy_o  = (state_q == S_PROBE);
        done_o  = (state_q == S_DONE);
    end

    assign probe_o  = probe_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: three instances (N=32/WAIT=0, N=32/WAIT=2, N=2/WAIT=0) each closed around a comparator model.
// Expected targets are queued at start; per-instance monitors pop on done and check result, latency and probe trail.
// The probe trail is predicted as "known high bits of T, plus the trial bit", derived from the step index.
module tb_sar_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    bit   ok = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    // ---------------- instance A: N=32, WAIT=0 ----------------
    logic        st_a, rdy_a, bsy_a, dn_a, lt_a;
    logic [31:0] pr_a, res_a, tg_a, last_a;
    logic [31:0] q_a[$];
    int          cyc_a = 0;
    assign lt_a = (tg_a < pr_a);

    sar_search #(.N(32), .WAIT(0)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(st_a), .ready_o(rdy_a), .busy_o(bsy_a),
        .probe_o(pr_a), .lt_i(lt_a), .done_o(dn_a), .result_o(res_a)
    );

    // ---------------- instance B: N=32, WAIT=2 ----------------
    logic        st_b, rdy_b, bsy_b, dn_b, lt_b;
    logic [31:0] pr_b, res_b, tg_b, last_b;
    logic [31:0] q_b[$];
    int          cyc_b = 0;
    bit          glitch_b = 1'b0;

    sar_search #(.N(32), .WAIT(2)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(st_b), .ready_o(rdy_b), .busy_o(bsy_b),
        .probe_o(pr_b), .lt_i(lt_b), .done_o(dn_b), .result_o(res_b)
    );

    // ---------------- instance C: N=2, WAIT=0 ----------------
    logic        st_c, rdy_c, bsy_c, dn_c, lt_c;
    logic [1:0]  pr_c, res_c, tg_c, last_c;
    logic [1:0]  q_c[$];
    int          cyc_c = 0;
    assign lt_c = (tg_c < pr_c);

    sar_search #(.N(2), .WAIT(0)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(st_c), .ready_o(rdy_c), .busy_o(bsy_c),
        .probe_o(pr_c), .lt_i(lt_c), .done_o(dn_c), .result_o(res_c)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Binary search on T: during step j (0-based) the bits of T above bit b are known and bit b is on trial.
    function automatic logic [63:0] exp_probe(logic [63:0] t, int n, int w, int c);
        int          b;
        logic [63:0] hi;
        b  = n - 1 - c / (w + 1);
        hi = (t >> (b + 1)) << (b + 1);
        return hi | (64'd1 << b);
    endfunction

    // Edge counters since the accepted start edge.
    always @(posedge clk) begin
        cyc_a <= (st_a && rdy_a) ? 0 : cyc_a + 1;
        cyc_b <= (st_b && rdy_b) ? 0 : cyc_b + 1;
        cyc_c <= (st_c && rdy_c) ? 0 : cyc_c + 1;
    end

    // Comparator for B; off-sample cycles get garbage (random or X) when glitching is enabled.
    always @(negedge clk) begin
        if (glitch_b && ((cyc_b + 1) % 3 != 0))
            lt_b = ($urandom_range(0, 2) == 2) ? 1'bx : 1'($urandom_range(0, 1));
        else
            lt_b = (tg_b < pr_b);
    end

    // Monitor A
    always @(negedge clk) if (ok) begin
        if (bsy_a) begin
            chk("ready_low_busy_a", rdy_a, 0);
            if (q_a.size() != 0) chk("probe_a", pr_a, exp_probe(q_a[0], 32, 0, cyc_a));
            else chk("busy_expected_a", q_a.size(), 1);
        end
        if (dn_a) begin
            chk("done_expected_a", q_a.size() != 0, 1);
            if (q_a.size() != 0) begin
                last_a = q_a.pop_front();
                chk("result_a", res_a, last_a);
                chk("latency_a", cyc_a, 32);
                chk("flags_done_a", {rdy_a, bsy_a}, 0);
            end
        end else begin
            chk("result_hold_a", res_a, last_a);
        end
    end

    // Monitor B
    always @(negedge clk) if (ok) begin
        if (bsy_b) begin
            chk("ready_low_busy_b", rdy_b, 0);
            if (q_b.size() != 0) chk("probe_b", pr_b, exp_probe(q_b[0], 32, 2, cyc_b));
            else chk("busy_expected_b", q_b.size(), 1);
        end
        if (dn_b) begin
            chk("done_expected_b", q_b.size() != 0, 1);
            if (q_b.size() != 0) begin
                last_b = q_b.pop_front();
                chk("result_b", res_b, last_b);
                chk("latency_b", cyc_b, 96);
                chk("flags_done_b", {rdy_b, bsy_b}, 0);
            end
        end else begin
            chk("result_hold_b", res_b, last_b);
        end
    end

    // Monitor C
    always @(negedge clk) if (ok) begin
        if (bsy_c) begin
            chk("ready_low_busy_c", rdy_c, 0);
            if (q_c.size() != 0) chk("probe_c", pr_c, exp_probe(64'(q_c[0]), 2, 0, cyc_c));
            else chk("busy_expected_c", q_c.size(), 1);
        end
        if (dn_c) begin
            chk("done_expected_c", q_c.size() != 0, 1);
            if (q_c.size() != 0) begin
                last_c = q_c.pop_front();
                chk("result_c", res_c, last_c);
                chk("latency_c", cyc_c, 2);
                chk("flags_done_c", {rdy_c, bsy_c}, 0);
            end
        end else begin
            chk("result_hold_c", res_c, last_c);
        end
    end

    function automatic logic rdy_of(int w);
        case (w)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    task automatic set_st(int w, logic v);
        case (w)
            0:       st_a = v;
            1:       st_b = v;
            default: st_c = v;
        endcase
    endtask

    // Wait for ready, queue the expected target, pulse start; optionally inject a stray start mid-search.
    task automatic go(int w, logic [31:0] t, int inj);
        int n = 0;
        @(negedge clk);
        while (!rdy_of(w) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", rdy_of(w), 1);
        case (w)
            0:       begin tg_a = t;      q_a.push_back(t);      end
            1:       begin tg_b = t;      q_b.push_back(t);      end
            default: begin tg_c = t[1:0]; q_c.push_back(t[1:0]); end
        endcase
        set_st(w, 1'b1);
        @(posedge clk);
        #1 set_st(w, 1'b0);
        if (inj > 0) begin
            repeat (inj) @(negedge clk);
            set_st(w, 1'b1);
            chk("inject_ready_low", rdy_of(w), 0);
            @(posedge clk);
            #1 set_st(w, 1'b0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q_a.size() + q_b.size() + q_c.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        tg_a = '0;   tg_b = '0;   tg_c = '0;
        last_a = '0; last_b = '0; last_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_probe_a", pr_a, 0);
        chk("reset_result_a", res_a, 0);
        chk("reset_flags_a", {rdy_a, bsy_a, dn_a}, 3'b100);
        chk("reset_flags_b", {rdy_b, bsy_b, dn_b}, 3'b100);
        chk("reset_flags_c", {rdy_c, bsy_c, dn_c}, 3'b100);
        rst_n = 1'b1;
        ok    = 1'b1;

        // N=2 exhaustive, back-to-back, twice
        for (int r = 0; r < 2; r++)
            for (int t = 0; t < 4; t++) go(2, 32'(t), 0);
        drain();

        // WAIT=2 with glitching lt during hold cycles
        glitch_b = 1'b1;
        go(1, 32'h1234_5678, 0);
        go(1, 32'h0000_0000, 0);
        go(1, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < 3; i++) go(1, $urandom, 0);
        drain();
        glitch_b = 1'b0;

        // N=32 directed boundaries
        go(0, 32'h0000_0000, 0);
        go(0, 32'hFFFF_FFFF, 0);
        go(0, 32'h8000_0000, 0);
        drain();

        // Reset in the middle of step 10
        go(0, 32'hDEAD_BEEF, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q_a.delete();
        last_a = '0; last_b = '0; last_c = '0;
        @(negedge clk);
        chk("midreset_probe", pr_a, 0);
        chk("midreset_result", res_a, 0);
        chk("midreset_flags", {rdy_a, bsy_a, dn_a}, 3'b100);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        go(0, 32'hDEAD_BEEF, 0);
        drain();

        // 512 random targets back-to-back, with stray starts injected mid-search
        for (int i = 0; i < 512; i++)
            go(0, $urandom, (i == 100) ? 7 : ((i == 300) ? 25 : 0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
